reqack_arbiter_n2one: RTL and testbench
=======================================

Name: reqack_arbiter_n2one

Overview:
- Parametrised N-to-1 four-phase req/ack arbiter. It is the successor of the two-input arbiter.
- Merges NPROD asynchronous producer channels onto one consumer channel.
- Synchronises all requests and the consumer ack into clk, and adds configurable synchroniser depth and selectable round-robin or fixed-priority arbitration.
- Unlike its predecessor, it serialises transactions: a new grant is issued only when the consumer handshake is fully idle. It also reports the granted source index.

Parameters:
- NPROD, 4: number of producer channels; legal range ≥2.
- DWIDTH, 8: data width per channel.
- SYNC_STAGES, 2: flip-flop depth of each req/ack synchroniser; legal range ≥2.
- PRIO_MODE, 0: arbitration mode. 0 = round-robin starting after the last grant; 1 = fixed priority, lowest index wins.
- SW, $clog2(NPROD): source index width (derived; do not override).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- prod_req  in  NPROD  per-producer request (asynchronous)
- prod_ack  out  NPROD  per-producer acknowledge
- prod_dat  in  NPROD*DWIDTH  producer data; channel i occupies [i*DWIDTH +: DWIDTH]; stable while prod_req[i] is high
- cons_req  out  1  consumer request
- cons_ack  in  1  consumer acknowledge (asynchronous)
- cons_dat  out  DWIDTH  registered data of the granted producer
- cons_src  out  SW  index of the granted producer
- busy  out  1  high whenever the FSM is not in IDLE

Behaviour:
- Reset values: prod_ack, cons_req, cons_dat, cons_src, busy, all synchronisers and pend[] are 0; last_grant = NPROD-1; FSM = IDLE.
- Reset is asynchronous and acts mid-transaction: all outputs drop immediately and the in-flight transaction is abandoned.
- Synchronisers: req_s[i] and ack_s are the outputs of SYNC_STAGES-deep shift registers.
- Request term: req_i[i] = req_s[i] | pend[i].
- Eligibility: eligible[i] = req_s[i] & ~prod_ack[i].
- Grant rule: exactly one grant per cycle, issued only in IDLE when any eligible[i] is set.
  - PRIO_MODE=0: winner is the first eligible index searching last_grant+1, last_grant+2, …, wrapping modulo NPROD.
  - PRIO_MODE=1: winner is the lowest eligible index.
- FSM states:
  - IDLE, on grant g (registered at the next edge): cons_req←1, cons_dat←prod_dat[g], cons_src←g, prod_ack[g]←1, pend[g]←1, last_grant←g; go to REQ.
  - REQ, when ack_s=1: cons_req←0; go to DONE.
  - DONE, when ack_s=0: pend[cons_src]←0; go to IDLE.
- cons_dat and cons_src hold their value from grant until the next grant.
- prod_ack[i] falls on the edge after req_i[i] falls, i.e. once the producer has dropped req AND the consumer handshake has completed.
  - This keeps each producer four-phase: ack cannot fall before the consumer has finished.
- A producer that keeps req high after its transaction is not re-granted until its req has been seen low and prod_ack[i] has been cleared.
- Latency (SYNC_STAGES=2, consumer idle): prod_req rising before edge 0 gives cons_req=1 and prod_ack=1 after edge 2 (req_s rises at edge 1).
  - General form: cons_req rises SYNC_STAGES edges after the first edge that samples req.
- Simultaneous requests: exactly one is granted; the others wait, still eligible, and are served on later IDLE visits per PRIO_MODE.
- A request arriving during REQ/DONE is not lost; it is granted on return to IDLE.
- Minimum gap between consecutive consumer transactions: 1 cycle spent in IDLE.

Test Plan:
- Single request: NPROD=4, SYNC_STAGES=2. prod_req[2]=1 with dat=8'hA5 → after 2 edges cons_req=1, cons_dat=A5, cons_src=2, prod_ack[2]=1, busy=1. Consumer ack high/low and producer req low → prod_ack[2] drops after both complete; no other ack toggles.
- Round-robin fairness: PRIO_MODE=0, all four requesting continuously, each re-requesting after its ack falls → grant order 0,1,2,3,0,1,…; no index granted twice before all others.
- Fixed priority: PRIO_MODE=1, prod_req=4'b1010 held → grant 1, then 3. Re-assert req[1] during 3's transaction → next grant is 1.
- Serialisation: grant 0; keep cons_ack low for 50 cycles while req[1]=1 → cons_req stays single; no second prod_ack until ack_s has risen and fallen; then grant 1.
- Slow producer: producer 0 drops req before the consumer acks → prod_ack[0] stays 1 until ack_s falls, then drops one cycle after.
- Mid-transaction reset: assert rst_n=0 in state REQ → cons_req, prod_ack, busy go 0 asynchronously. After release with requests held, the first grant goes to index 0 (round-robin).

Source files
------------

// File: rtl/reqack_arbiter_n2one.sv
`default_nettype none
// ============================================================================
// Module   : reqack_arbiter_n2one
// Brief    : N-to-1 four-phase req/ack arbiter, serialised, RR or fixed prio.
// Revision : 1.0
// ============================================================================
module reqack_arbiter_n2one #(
  parameter int NPROD       = 4,
  parameter int DWIDTH      = 8,
  parameter int SYNC_STAGES = 2,
  parameter int PRIO_MODE   = 0,
  parameter int SW          = $clog2(NPROD)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NPROD-1:0]        prod_req,
  output logic [NPROD-1:0]        prod_ack,
  input  logic [NPROD*DWIDTH-1:0] prod_dat,
  output logic                    cons_req,
  input  logic                    cons_ack,
  output logic [DWIDTH-1:0]       cons_dat,
  output logic [SW-1:0]           cons_src,
  output logic                    busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [SYNC_STAGES-1:0][NPROD-1:0] req_sync_q;
  logic [SYNC_STAGES-1:0]            ack_sync_q;
  logic [NPROD-1:0]                  req_s;
  logic                              ack_s;

  logic [1:0]        state_q,      state_d;
  logic              cons_req_q,   cons_req_d;
  logic [DWIDTH-1:0] cons_dat_q,   cons_dat_d;
  logic [SW-1:0]     cons_src_q,   cons_src_d;
  logic [NPROD-1:0]  prod_ack_q,   prod_ack_d;
  logic [NPROD-1:0]  pend_q,       pend_d;
  logic [SW-1:0]     last_grant_q, last_grant_d;

  logic [NPROD-1:0]  req_i;
  logic [NPROD-1:0]  eligible;
  logic              grant_vld;
  logic [SW-1:0]     grant_idx;
  logic [SW-1:0]     hi_idx;
  logic [SW-1:0]     lo_idx;
  logic              hi_vld;
  logic [DWIDTH-1:0] grant_dat;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_sync_q <= '0;
      ack_sync_q <= '0;
    end else begin
      req_sync_q <= {req_sync_q[SYNC_STAGES-2:0], prod_req};
      ack_sync_q <= {ack_sync_q[SYNC_STAGES-2:0], cons_ack};
    end
  end

  assign req_s = req_sync_q[SYNC_STAGES-1];
  assign ack_s = ack_sync_q[SYNC_STAGES-1];

  // pend keeps the producer's ack up until the consumer side has fully closed
  assign req_i    = req_s | pend_q;
  assign eligible = req_s & ~prod_ack_q;
  assign grant_vld = |eligible;

  // Descending scan leaves the lowest match; hi_* is the lowest above last_grant
  always_comb begin
    hi_vld = 1'b0;
    hi_idx = '0;
    lo_idx = '0;
    for (int i = NPROD - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        lo_idx = SW'(i);
        if (i > int'(last_grant_q)) begin
          hi_idx = SW'(i);
          hi_vld = 1'b1;
        end
      end
    end
    grant_idx = ((PRIO_MODE == 0) && hi_vld) ? hi_idx : lo_idx;
  end

  always_comb begin
    grant_dat = '0;
    for (int i = 0; i < NPROD; i++) begin
      if (grant_idx == SW'(i)) grant_dat = prod_dat[i*DWIDTH +: DWIDTH];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cons_req_q   <= 1'b0;
      cons_dat_q   <= '0;
      cons_src_q   <= '0;
      prod_ack_q   <= '0;
      pend_q       <= '0;
      last_grant_q <= SW'(NPROD - 1);
    end else begin
      state_q      <= state_d;
      cons_req_q   <= cons_req_d;
      cons_dat_q   <= cons_dat_d;
      cons_src_q   <= cons_src_d;
      prod_ack_q   <= prod_ack_d;
      pend_q       <= pend_d;
      last_grant_q <= last_grant_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cons_req_d   = cons_req_q;
    cons_dat_d   = cons_dat_q;
    cons_src_d   = cons_src_q;
    prod_ack_d   = prod_ack_q & req_i;
    pend_d       = pend_q;
    last_grant_d = last_grant_q;
    case (state_q)
      S_IDLE: begin
        if (grant_vld) begin
          state_d               = S_REQ;
          cons_req_d            = 1'b1;
          cons_dat_d            = grant_dat;
          cons_src_d            = grant_idx;
          prod_ack_d[grant_idx] = 1'b1;
          pend_d[grant_idx]     = 1'b1;
          last_grant_d          = grant_idx;
        end
      end
      S_REQ: begin
        if (ack_s) begin
          cons_req_d = 1'b0;
          state_d    = S_DONE;
        end
      end
      S_DONE: begin
        if (!ack_s) begin
          pend_d[cons_src_q] = 1'b0;
          state_d            = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy     = (state_q != S_IDLE);
    cons_req = cons_req_q;
    cons_dat = cons_dat_q;
    cons_src = cons_src_q;
    prod_ack = prod_ack_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_reqack_arbiter_n2one.sv
`default_nettype none
// ============================================================================
// Module   : tb_reqack_arbiter_n2one
// Brief    : Directed bench; one round-robin and one fixed-priority instance.
// Revision : 1.0
// ============================================================================
module tb_reqack_arbiter_n2one;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  rr_req, rr_ack, fp_req, fp_ack;
  logic [31:0] rr_dat, fp_dat;
  logic        rr_creq, fp_creq, rr_cack, fp_cack;
  logic [7:0]  rr_cdat, fp_cdat;
  logic [1:0]  rr_src, fp_src;
  logic        rr_busy, fp_busy;
  int          n_tests = 0;
  int          n_fail  = 0;

  always #5 clk = ~clk;

  reqack_arbiter_n2one #(.NPROD(4), .DWIDTH(8), .SYNC_STAGES(2), .PRIO_MODE(0)) u_rr (
    .clk(clk), .rst_n(rst_n), .prod_req(rr_req), .prod_ack(rr_ack), .prod_dat(rr_dat),
    .cons_req(rr_creq), .cons_ack(rr_cack), .cons_dat(rr_cdat), .cons_src(rr_src),
    .busy(rr_busy)
  );

  reqack_arbiter_n2one #(.NPROD(4), .DWIDTH(8), .SYNC_STAGES(2), .PRIO_MODE(1)) u_fp (
    .clk(clk), .rst_n(rst_n), .prod_req(fp_req), .prod_ack(fp_ack), .prod_dat(fp_dat),
    .cons_req(fp_creq), .cons_ack(fp_cack), .cons_dat(fp_cdat), .cons_src(fp_src),
    .busy(fp_busy)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_rr(input logic lvl, input string tag);
    int c = 0;
    while (rr_creq !== lvl && c < 200) begin
      tick(1);
      c++;
    end
    chk(tag, {31'd0, rr_creq}, {31'd0, lvl});
  endtask

  task automatic wait_fp(input logic lvl, input string tag);
    int c = 0;
    while (fp_creq !== lvl && c < 200) begin
      tick(1);
      c++;
    end
    chk(tag, {31'd0, fp_creq}, {31'd0, lvl});
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    rr_req  = '0;
    fp_req  = '0;
    rr_cack = 1'b0;
    fp_cack = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int g;
    int bad;
    rst_n = 1'b0; rr_req = '0; fp_req = '0; rr_cack = 1'b0; fp_cack = 1'b0;
    rr_dat = '0; fp_dat = '0;
    tick(2);
    chk("rst_cons_req", rr_creq, 0);
    chk("rst_prod_ack", rr_ack, 0);
    chk("rst_busy",     rr_busy, 0);
    chk("rst_cons_dat", rr_cdat, 0);
    chk("rst_cons_src", rr_src, 0);
    chk("rst_fp_ack",   fp_ack, 0);
    rst_n = 1'b1;
    tick(1);

    // Single request on channel 2
    rr_dat = 32'h00A5_0000;
    rr_req = 4'b0100;
    tick(2);
    chk("single_latency_early", rr_creq, 0);
    tick(1);
    chk("single_cons_req", rr_creq, 1);
    chk("single_cons_dat", rr_cdat, 8'hA5);
    chk("single_cons_src", rr_src, 2);
    chk("single_prod_ack", rr_ack, 4'b0100);
    chk("single_busy",     rr_busy, 1);
    rr_cack = 1'b1;
    tick(3);
    chk("single_req_drop", rr_creq, 0);
    chk("single_ack_held", rr_ack, 4'b0100);
    rr_req  = 4'b0000;
    rr_cack = 1'b0;
    tick(3);
    chk("single_idle",      rr_busy, 0);
    chk("single_ack_still", rr_ack, 4'b0100);
    tick(1);
    chk("single_ack_fall",  rr_ack, 4'b0000);
    chk("single_dat_hold",  rr_cdat, 8'hA5);
    chk("single_src_hold",  rr_src, 2);
    tick(5);
    chk("single_no_regrant", rr_creq, 0);

    // Round-robin fairness with continuous re-requests
    do_reset();
    rr_dat = 32'h1312_1110;
    rr_req = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      g = k % 4;
      wait_rr(1'b1, "rr_grant_wait");
      chk("rr_src",     rr_src, g);
      chk("rr_dat",     rr_cdat, 8'h10 + g);
      chk("rr_ack_one", rr_ack, 32'd1 << g);
      rr_cack   = 1'b1;
      rr_req[g] = 1'b0;
      wait_rr(1'b0, "rr_release_wait");
      rr_cack = 1'b0;
      bad = 0;
      while (rr_ack[g] !== 1'b0 && bad < 200) begin
        tick(1);
        bad++;
      end
      chk("rr_ack_fall", rr_ack[g], 0);
      rr_req[g] = 1'b1;
    end

    // Fixed priority
    do_reset();
    fp_dat = 32'h3322_1100;
    fp_req = 4'b1010;
    wait_fp(1'b1, "fp_wait1");
    chk("fp_src_first", fp_src, 1);
    chk("fp_dat_first", fp_cdat, 8'h11);
    fp_cack   = 1'b1;
    fp_req[1] = 1'b0;
    wait_fp(1'b0, "fp_rel1");
    fp_cack = 1'b0;
    wait_fp(1'b1, "fp_wait2");
    chk("fp_src_second", fp_src, 3);
    chk("fp_dat_second", fp_cdat, 8'h33);
    chk("fp_ack_second", fp_ack, 4'b1000);
    fp_req[1] = 1'b1;
    fp_cack   = 1'b1;
    wait_fp(1'b0, "fp_rel2");
    fp_cack = 1'b0;
    wait_fp(1'b1, "fp_wait3");
    chk("fp_src_third", fp_src, 1);
    chk("fp_ack_third", fp_ack, 4'b1010);
    chk("fp_dat_third", fp_cdat, 8'h11);

    // Serialisation: consumer stalls while another producer waits
    do_reset();
    rr_dat = 32'h1312_1110;
    rr_req = 4'b0011;
    wait_rr(1'b1, "ser_wait");
    chk("ser_src0", rr_src, 0);
    chk("ser_ack0", rr_ack, 4'b0001);
    bad = 0;
    for (int k = 0; k < 50; k++) begin
      tick(1);
      if (rr_creq !== 1'b1 || rr_ack !== 4'b0001) bad++;
    end
    chk("ser_hold", bad, 0);
    rr_cack   = 1'b1;
    rr_req[0] = 1'b0;
    wait_rr(1'b0, "ser_rel");
    chk("ser_no_second_ack", rr_ack, 4'b0001);
    chk("ser_dat_hold",      rr_cdat, 8'h10);
    rr_cack = 1'b0;
    wait_rr(1'b1, "ser_wait2");
    chk("ser_src1", rr_src, 1);
    chk("ser_ack1", rr_ack, 4'b0010);
    chk("ser_dat1", rr_cdat, 8'h11);

    // Slow producer drops req before the consumer acks
    do_reset();
    rr_req = 4'b0001;
    wait_rr(1'b1, "slow_wait");
    rr_req = 4'b0000;
    tick(5);
    chk("slow_ack_held", rr_ack, 4'b0001);
    chk("slow_req_held", rr_creq, 1);
    rr_cack = 1'b1;
    wait_rr(1'b0, "slow_rel");
    rr_cack = 1'b0;
    tick(2);
    chk("slow_ack_b1", rr_ack, 4'b0001);
    tick(1);
    chk("slow_ack_b2", rr_ack, 4'b0001);
    chk("slow_idle",   rr_busy, 0);
    tick(1);
    chk("slow_ack_fall", rr_ack, 4'b0000);

    // Asynchronous reset in REQ
    do_reset();
    rr_req = 4'b0100;
    wait_rr(1'b1, "mrst_wait");
    chk("mrst_src2", rr_src, 2);
    rr_req = 4'b1111;
    tick(1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mrst_cons_req", rr_creq, 0);
    chk("mrst_prod_ack", rr_ack, 0);
    chk("mrst_busy",     rr_busy, 0);
    tick(2);
    rst_n = 1'b1;
    wait_rr(1'b1, "mrst_wait2");
    chk("mrst_src0", rr_src, 0);
    chk("mrst_ack0", rr_ack, 4'b0001);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
